// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one sync FIFO among NUM_REQ producers.
// Optional stall watchdog is built when FIFO_ARB_WDOG_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_clear,
  input  logic                          fifo_full,
  input  logic                          fifo_afull,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          timeout
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || MAX_BURST < 1 || TIMEOUT < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: invalid parameter set");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]   winner;
  logic                  winner_vld;
  logic [ID_WIDTH-1:0]   rr_next;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  wdog_fire;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    winner     = rr_ptr_q;
    winner_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ)]) begin
        winner     = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
        winner_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rr_next = ID_WIDTH'((int'(grant_id_q) + 1) % NUM_REQ);
  assign accept  = (state_q == BURST) && sel_valid && !fifo_full && !flush;

`ifdef FIFO_ARB_WDOG_EN
  localparam int SC_W = $clog2(TIMEOUT) + 1;

  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

  assign wdog_fire = (state_q == BURST) && !accept && !flush &&
                     (stall_cnt_q == SC_W'(TIMEOUT - 1));

  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == BURST) && !accept && !flush && !wdog_fire) begin
      stall_cnt_d = SC_W'(stall_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign timeout = wdog_fire;
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_afull && winner_vld) begin
            grant_id_d = winner;
            beat_cnt_d = '0;
            state_d    = BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt_d = BC_W'(beat_cnt_q + 1'b1);
            if (sel_last || (beat_cnt_q == BC_W'(MAX_BURST - 1))) begin
              state_d    = IDLE;
              rr_ptr_d   = rr_next;
              beat_cnt_d = '0;
            end
          end else if (wdog_fire) begin
            state_d    = IDLE;
            rr_ptr_d   = rr_next;
            beat_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  // Data path is a pure mux so the beat lands in the FIFO on the accepting edge.
  assign fifo_wen   = accept;
  assign fifo_wdata = (state_q == BURST) ? sel_data : '0;
  assign fifo_clear = flush;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers feed per-requester beat queues,
// expected FIFO writes are queued in order and checked by an independent monitor.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wen;
  logic [7:0]  fifo_wdata;
  logic        fifo_clear;
  logic        fifo_full;
  logic        fifo_afull;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;

  fifo_wr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_clear (fifo_clear),
    .fifo_full  (fifo_full),
    .fifo_afull (fifo_afull),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

`ifdef FIFO_ARB_WDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  logic [8:0] rq [4][$];
  beat_t      expq [$];
  logic [3:0] take;
  time        last_wen_t;
  time        t0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected beat whenever the DUT writes the FIFO.
  initial begin
    beat_t e;
    take       = '0;
    last_wen_t = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        take = '0;
      end else begin
        take = req_ready & req_valid;
        if (fifo_wen) begin
          last_wen_t = $time;
          if (expq.size() == 0) begin
            chk("unexpected_wen", {22'd0, grant_id, fifo_wdata}, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk("wdata", {24'd0, fifo_wdata}, {24'd0, e.data});
            chk("wen_grant", {30'd0, grant_id}, {30'd0, e.id});
            chk("ready_onehot", {28'd0, req_ready}, 32'd1 << e.id);
          end
        end else begin
          chk("ready_idle", {28'd0, req_ready}, 32'd0);
        end
      end
    end
  end

  task automatic drive_update();
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive_update();
  endtask

  task automatic cyc();
    tick();
    @(negedge clk);
  endtask

  task automatic give(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_beat(input int r, input logic [7:0] d);
    expq.push_back({2'(r), d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) rq[i].delete();
    drive_update();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_wen", {31'd0, fifo_wen}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_clear", {31'd0, fifo_clear}, 32'd0);
    chk("rst_wdata", {24'd0, fifo_wdata}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);

    // Single requester, 3 beats with last on the third.
    tick();
    give(0, 8'hA1, 1'b0); give(0, 8'hA2, 1'b0); give(0, 8'hA3, 1'b1);
    expect_beat(0, 8'hA1); expect_beat(0, 8'hA2); expect_beat(0, 8'hA3);
    drive_update();
    @(negedge clk);
    chk("t1_arb_cycle", {31'd0, busy}, 32'd0);
    repeat (3) begin
      cyc();
      chk("t1_in_burst", {31'd0, busy}, 32'd1);
    end
    cyc();
    chk("t1_back_idle", {31'd0, busy}, 32'd0);

    // rr_ptr must now be 1: requester 1 wins over 0.
    tick();
    give(0, 8'hB0, 1'b1); give(1, 8'hB1, 1'b1);
    expect_beat(1, 8'hB1); expect_beat(0, 8'hB0);
    drive_update();
    @(negedge clk);
    repeat (4) cyc();
    chk("rr_after_t1", {30'd0, grant_id}, 32'd0);
    chk("rr_idle", {31'd0, busy}, 32'd0);

    // Round-robin rotation of 4-beat bursts terminated by MAX_BURST.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        give(r, 8'(16 * r + b), 1'b0);
        expect_beat(r, 8'(16 * r + b));
      end
    end
    for (int b = 0; b < 4; b++) begin
      give(0, 8'(8'h80 + b), 1'b0);
      expect_beat(0, 8'(8'h80 + b));
    end
    drive_update();
    @(negedge clk);
    t0 = $time;
    repeat (5) cyc();
    chk("t2_gap_idle", {31'd0, busy}, 32'd0);
    repeat (20) cyc();
    chk("t2_rotation_cycles", 32'((last_wen_t - t0) / 10), 32'd24);
    chk("t2_last_grant", {30'd0, grant_id}, 32'd0);

    // Backpressure: fifo_full for 3 cycles after two beats.
    tick();
    for (int b = 0; b < 4; b++) begin
      give(2, 8'(8'hC0 + b), 1'b0);
      expect_beat(2, 8'(8'hC0 + b));
    end
    drive_update();
    @(negedge clk);
    cyc(); cyc();
    for (int s = 0; s < 3; s++) begin
      tick();
      fifo_full = 1'b1;
      @(negedge clk);
      chk("t3_stall_wen", {31'd0, fifo_wen}, 32'd0);
      chk("t3_stall_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t3_resume_wen", {31'd0, fifo_wen}, 32'd1);
    cyc();
    chk("t3_last_beat_busy", {31'd0, busy}, 32'd1);
    cyc();
    chk("t3_end_idle", {31'd0, busy}, 32'd0);

    // Admission gated by fifo_afull in IDLE only.
    tick();
    fifo_afull = 1'b1;
    give(3, 8'hD0, 1'b1);
    expect_beat(3, 8'hD0);
    drive_update();
    @(negedge clk);
    chk("t4_afull_hold0", {31'd0, busy}, 32'd0);
    cyc();
    chk("t4_afull_hold1", {31'd0, busy}, 32'd0);
    cyc();
    chk("t4_afull_hold2", {31'd0, busy}, 32'd0);
    tick();
    fifo_afull = 1'b0;
    @(negedge clk);
    chk("t4_arb_cycle", {31'd0, busy}, 32'd0);
    tick();
    fifo_afull = 1'b1;
    @(negedge clk);
    chk("t4_granted", {31'd0, busy}, 32'd1);
    chk("t4_grant_id", {30'd0, grant_id}, 32'd3);
    chk("t4_afull_ignored", {31'd0, fifo_wen}, 32'd1);
    tick();
    fifo_afull = 1'b0;
    @(negedge clk);
    chk("t4_end_idle", {31'd0, busy}, 32'd0);

    // Flush after two beats; the rest is re-arbitrated as a fresh burst.
    tick();
    give(2, 8'hE0, 1'b0); give(2, 8'hE1, 1'b0); give(2, 8'hE2, 1'b0); give(2, 8'hE3, 1'b1);
    expect_beat(2, 8'hE0); expect_beat(2, 8'hE1); expect_beat(2, 8'hE2); expect_beat(2, 8'hE3);
    drive_update();
    @(negedge clk);
    cyc(); cyc();
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_clear", {31'd0, fifo_clear}, 32'd1);
    chk("t5_no_wen", {31'd0, fifo_wen}, 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_clear_off", {31'd0, fifo_clear}, 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_grant_kept", {30'd0, grant_id}, 32'd2);
    repeat (3) cyc();
    chk("t5_end_idle", {31'd0, busy}, 32'd0);

    // Granted requester goes silent after one beat.
    tick();
    give(1, 8'hF0, 1'b0); give(2, 8'h90, 1'b1);
    expect_beat(1, 8'hF0);
`ifdef FIFO_ARB_WDOG_EN
    expect_beat(2, 8'h90);
`endif
    drive_update();
    @(negedge clk);
    repeat (16) cyc();
    chk("t6_no_early_timeout", {31'd0, timeout}, 32'd0);
    cyc();
    chk("t6_timeout_pulse", {31'd0, timeout}, {31'd0, WD});
    chk("t6_busy_at_pulse", {31'd0, busy}, 32'd1);
    cyc();
    chk("t6_after_pulse", {31'd0, busy}, {31'd0, !WD});
    chk("t6_pulse_width", {31'd0, timeout}, 32'd0);
    cyc();
    chk("t6_busy_next", {31'd0, busy}, 32'd1);
    chk("t6_grant_next", {30'd0, grant_id}, WD ? 32'd2 : 32'd1);
`ifndef FIFO_ARB_WDOG_EN
    tick();
    give(1, 8'hF1, 1'b1);
    expect_beat(1, 8'hF1);
    expect_beat(2, 8'h90);
    drive_update();
    @(negedge clk);
`endif
    repeat (6) cyc();
    chk("final_idle", {31'd0, busy}, 32'd0);
    chk("exp_queue_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
